uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Parameters
REQ-001 SHALL have parameter ESC, default 8'hB1, the frame escape byte.
REQ-002 SHALL have parameter MAX_LEN, default 8, the maximum payload bytes per packet (1..15).

Interface
REQ-003 SHALL have port CLK_I, input, 1, the single clock.
REQ-004 SHALL have port RST_I, input, 1, an asynchronous active-high reset.
REQ-005 SHALL have port REQ_VALID_I, input, 3, the packet request per requester (0=DMI, 1=STB0, 2=STB1).
REQ-006 SHALL have port REQ_HDR_I, input, 3x8, the header byte per requester, sampled at grant.
REQ-007 SHALL have port REQ_LEN_I, input, 3x4, the payload length per requester, sampled at grant.
REQ-008 SHALL have port GRANT_O, output, 3, the one-hot grant, registered.
REQ-009 SHALL have port DATA_I, input, 3x8, the payload byte per requester.
REQ-010 SHALL have port DATA_VALID_I, input, 3, payload byte valid per requester.
REQ-011 SHALL have port DATA_READY_O, output, 3, payload byte accepted per requester.
REQ-012 SHALL have port TX_DATA_O, output, 8, the byte to the UART transmitter.
REQ-013 SHALL have port TX_WRITE_O, output, 1, TX byte valid.
REQ-014 SHALL have port TX_READY_I, input, 1, UART transmitter able to accept a byte.

Function
REQ-015 SHALL transfer a TX byte only in a cycle where TX_WRITE_O and TX_READY_I are both high; TX_DATA_O SHALL stay stable while TX_WRITE_O is high and TX_READY_I is low.
REQ-016 SHALL transfer a payload byte from requester g only in a cycle where DATA_VALID_I[g] and DATA_READY_O[g] are both high.
REQ-017 SHALL implement the states IDLE, ESC, HDR, DATA, STUFF.
REQ-018 In IDLE with any REQ_VALID_I high, SHALL grant the first requester at or after the round-robin pointer (modulo 3), latch its HDR and its LEN clamped to MAX_LEN, set GRANT_O, and enter ESC the next cycle.
REQ-019 In ESC, SHALL drive TX_DATA_O=ESC with TX_WRITE_O=1, and on transfer enter HDR.
REQ-020 In HDR, SHALL drive the latched header with TX_WRITE_O=1, and on transfer enter DATA, or enter IDLE if the latched LEN is 0.
REQ-021 In DATA:
- TX_DATA_O SHALL equal DATA_I[g], TX_WRITE_O SHALL equal DATA_VALID_I[g], and DATA_READY_O[g] SHALL equal TX_READY_I (combinational pass-through); all other DATA_READY_O bits SHALL be 0.
- Each transfer SHALL decrement the 4-bit remaining count.
- A transferred byte equal to ESC SHALL enter STUFF.
- Otherwise, on count reaching 0, SHALL enter IDLE.
REQ-022 In STUFF, SHALL emit ESC with TX_WRITE_O=1 and DATA_READY_O all 0; on transfer it SHALL return to DATA, or to IDLE if the count is 0.
REQ-023 On entry to IDLE from a packet, SHALL clear GRANT_O and set the pointer to (g+1) mod 3; IDLE SHALL last at least one cycle between packets.
REQ-024 SHALL ignore REQ_VALID_I, REQ_HDR_I and REQ_LEN_I changes after grant until the packet ends; a dropped request SHALL NOT abort the packet.
REQ-025 Low DATA_VALID_I[g] in DATA SHALL stall the packet indefinitely without emitting a byte.
REQ-026 Total latency from REQ_VALID_I high in IDLE with TX_READY_I=1 SHALL be: GRANT_O next cycle, ESC transferred that same cycle, header one cycle later.

Reset
REQ-027 RST_I high SHALL immediately force IDLE, GRANT_O=0, TX_WRITE_O=0, TX_DATA_O=0, DATA_READY_O=0, pointer=0, and count=0, including mid-packet; the partial frame is discarded.
REQ-028 After RST_I is deasserted, SHALL evaluate requests from the first rising clock edge.

Verification
REQ-029 Single request: REQ0, HDR=8'h04, LEN=2, data 8'h11, 8'h22, TX_READY_I=1 -> TX sequence B1, 04, 11, 22; GRANT_O=3'b001 for 4 cycles.
REQ-030 Escape stuffing: LEN=2, data B1, 7F -> TX sequence B1, HDR, B1, B1, 7F; DATA_READY_O pulses exactly twice.
REQ-031 Round-robin: all three requesters held valid after reset, LEN=1 each -> grant order 0, 1, 2, 0, with one IDLE cycle between packets.
REQ-032 Backpressure: TX_READY_I low 5 cycles during HDR -> TX_DATA_O is held at the header byte, no byte is lost, and the sequence completes unchanged.
REQ-033 LEN=0 and LEN=15 with MAX_LEN=8 -> header-only frame; 8-byte payload frame, respectively.
REQ-034 RST_I asserted during DATA after 1 of 4 bytes -> outputs are 0 asynchronously; the next packet starts with ESC, granted from requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: request, payload and UART TX handshakes shared by three requesters and the arbiter
interface uart_tx_arbiter_if;
    logic [2:0]      REQ_VALID_I;
    logic [2:0][7:0] REQ_HDR_I;
    logic [2:0][3:0] REQ_LEN_I;
    logic [2:0]      GRANT_O;
    logic [2:0][7:0] DATA_I;
    logic [2:0]      DATA_VALID_I;
    logic [2:0]      DATA_READY_O;
    logic [7:0]      TX_DATA_O;
    logic            TX_WRITE_O;
    logic            TX_READY_I;
    modport slave (
        input  REQ_VALID_I, REQ_HDR_I, REQ_LEN_I, DATA_I, DATA_VALID_I, TX_READY_I,
        output GRANT_O, DATA_READY_O, TX_DATA_O, TX_WRITE_O
    );
    modport master (
        output REQ_VALID_I, REQ_HDR_I, REQ_LEN_I, DATA_I, DATA_VALID_I, TX_READY_I,
        input  GRANT_O, DATA_READY_O, TX_DATA_O, TX_WRITE_O
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter framing ESC+header+escape-stuffed payload onto one UART TX byte stream
module uart_tx_arbiter #(
    parameter logic [7:0] ESC     = 8'hB1,
    parameter int          MAX_LEN = 8
) (
    input logic              CLK_I,
    input logic              RST_I,
    uart_tx_arbiter_if.slave bus
);
    typedef enum logic [2:0] {ST_IDLE, ST_ESC, ST_HDR, ST_DATA, ST_STUFF} state_t;
    localparam logic [3:0] MAX_L = 4'(MAX_LEN);
    state_t     state_q, state_d;
    logic [2:0] grant_q, grant_d;
    logic [1:0] g_q, g_d, ptr_q, ptr_d, sel;
    logic [7:0] hdr_q, hdr_d, tx_data;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] ready;
    logic       tx_write;
    function automatic logic [1:0] rr_idx(input logic [1:0] base, input int off);
        logic [2:0] s;
        s = {1'b0, base} + 3'(off);
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction
    // first valid requester at or after the round-robin pointer
    always_comb begin
        sel = ptr_q;
        for (int k = 2; k >= 0; k--)
            if (bus.REQ_VALID_I[rr_idx(ptr_q, k)]) sel = rr_idx(ptr_q, k);
    end
    // framing FSM: next state, latched packet context and TX/payload handshake outputs
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        g_d      = g_q;
        hdr_d    = hdr_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        tx_data  = 8'h00;
        tx_write = 1'b0;
        ready    = 3'b000;
        case (state_q)
            ST_IDLE: if (|bus.REQ_VALID_I) begin
                g_d     = sel;
                hdr_d   = bus.REQ_HDR_I[sel];
                cnt_d   = (bus.REQ_LEN_I[sel] > MAX_L) ? MAX_L : bus.REQ_LEN_I[sel];
                grant_d = 3'b001 << sel;
                state_d = ST_ESC;
            end
            ST_ESC: begin
                tx_data  = ESC;
                tx_write = 1'b1;
                if (bus.TX_READY_I) state_d = ST_HDR;
            end
            ST_HDR: begin
                tx_data  = hdr_q;
                tx_write = 1'b1;
                if (bus.TX_READY_I) state_d = (cnt_q == 4'd0) ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                tx_data    = bus.DATA_I[g_q];
                tx_write   = bus.DATA_VALID_I[g_q];
                ready[g_q] = bus.TX_READY_I;
                if (tx_write && bus.TX_READY_I) begin
                    cnt_d = cnt_q - 4'd1;
                    if (tx_data == ESC) state_d = ST_STUFF;
                    else if (cnt_d == 4'd0) state_d = ST_IDLE;
                end
            end
            ST_STUFF: begin
                tx_data  = ESC;
                tx_write = 1'b1;
                if (bus.TX_READY_I) state_d = (cnt_q == 4'd0) ? ST_IDLE : ST_DATA;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_IDLE && state_q != ST_IDLE) begin
            grant_d = 3'b000;
            ptr_d   = rr_idx(g_q, 1);
        end
    end
    // state and packet context registers; reset drops any partial frame
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= ST_IDLE;
            grant_q <= 3'b000;
            g_q     <= 2'd0;
            ptr_q   <= 2'd0;
            hdr_q   <= 8'h00;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
            hdr_q   <= hdr_d;
            cnt_q   <= cnt_d;
        end
    end
    assign bus.GRANT_O      = grant_q;
    assign bus.TX_DATA_O    = tx_data;
    assign bus.TX_WRITE_O   = tx_write;
    assign bus.DATA_READY_O = ready;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed-vector bench for the UART TX packet arbiter
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [7:0] pay [3][16];
    int   rd [3];
    int   wr [3];
    logic [2:0] dfire = 3'b000;
    logic [7:0] tx_log [$];
    logic [2:0] grant_log [$];
    int   rd_pulses = 0;
    uart_tx_arbiter_if bus ();
    uart_tx_arbiter #(.ESC(8'hB1), .MAX_LEN(8)) dut (.CLK_I(clk), .RST_I(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic refresh();
        for (int r = 0; r < 3; r++) begin
            bus.DATA_VALID_I[r] = rd[r] < wr[r];
            bus.DATA_I[r]       = pay[r][rd[r] & 15];
        end
    endtask
    task automatic push(input int r, input logic [7:0] b);
        if (wr[r] < 16) begin
            pay[r][wr[r]] = b;
            wr[r]++;
        end
        refresh();
    endtask
    task automatic clear_pay();
        for (int r = 0; r < 3; r++) begin
            rd[r] = 0;
            wr[r] = 0;
        end
        dfire = 3'b000;
        refresh();
    endtask
    task automatic clear_logs();
        tx_log.delete();
        grant_log.delete();
        rd_pulses = 0;
    endtask
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #3;
    endtask
    task automatic req(input int r, input logic [7:0] h, input logic [3:0] l);
        bus.REQ_HDR_I[r] = h;
        bus.REQ_LEN_I[r] = l;
    endtask
    // payload source: retire bytes accepted at the last edge and present the next one
    always @(posedge clk) begin
        #1;
        for (int r = 0; r < 3; r++) if (dfire[r]) rd[r]++;
        dfire = 3'b000;
        refresh();
    end
    // monitor: record TX transfers, payload handshakes and grant once per cycle
    always @(negedge clk) begin
        if (bus.TX_WRITE_O && bus.TX_READY_I) tx_log.push_back(bus.TX_DATA_O);
        dfire = bus.DATA_VALID_I & bus.DATA_READY_O;
        rd_pulses += $countones(dfire);
        grant_log.push_back(bus.GRANT_O);
    end
    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        n_cmp++; if (bus.GRANT_O !== 3'b000) begin n_bad++; $display("FAIL reset_grant got=%b exp=000", bus.GRANT_O); end
        n_cmp++; if (bus.TX_WRITE_O !== 1'b0) begin n_bad++; $display("FAIL reset_txw got=%b exp=0", bus.TX_WRITE_O); end
        n_cmp++; if (bus.TX_DATA_O !== 8'h00) begin n_bad++; $display("FAIL reset_txd got=%h exp=00", bus.TX_DATA_O); end
        n_cmp++; if (bus.DATA_READY_O !== 3'b000) begin n_bad++; $display("FAIL reset_rdy got=%b exp=000", bus.DATA_READY_O); end
        rst = 1'b0;
        clear_pay();
        tick(3);
        n_cmp++; if (bus.GRANT_O !== 3'b000) begin n_bad++; $display("FAIL idle_grant got=%b exp=000", bus.GRANT_O); end
    endtask
    task automatic test_single();
        logic [7:0] e [$];
        int ng;
        e = '{8'hB1, 8'h04, 8'h11, 8'h22};
        clear_pay(); push(0, 8'h11); push(0, 8'h22); req(0, 8'h04, 4'd2);
        clear_logs();
        bus.REQ_VALID_I = 3'b001;
        tick();
        bus.REQ_VALID_I = 3'b000;
        tick(7);
        n_cmp++; if (tx_log.size() !== e.size()) begin n_bad++; $display("FAIL single_len got=%0d exp=%0d", tx_log.size(), e.size()); end
        for (int i = 0; i < e.size(); i++) begin
            n_cmp++; if ((i < tx_log.size() ? tx_log[i] : 8'hxx) !== e[i]) begin n_bad++; $display("FAIL single_byte%0d got=%h exp=%h", i, (i < tx_log.size() ? tx_log[i] : 8'hxx), e[i]); end
        end
        n_cmp++; if (grant_log[1] !== 3'b001) begin n_bad++; $display("FAIL single_latency got=%b exp=001", grant_log[1]); end
        ng = 0;
        foreach (grant_log[i]) if (grant_log[i] == 3'b001) ng++;
        n_cmp++; if (ng !== 4) begin n_bad++; $display("FAIL single_grant_cycles got=%0d exp=4", ng); end
    endtask
    task automatic test_stuff();
        logic [7:0] e [$];
        e = '{8'hB1, 8'h5A, 8'hB1, 8'hB1, 8'h7F};
        clear_pay(); push(1, 8'hB1); push(1, 8'h7F); req(1, 8'h5A, 4'd2);
        clear_logs();
        bus.REQ_VALID_I = 3'b010;
        tick();
        bus.REQ_VALID_I = 3'b000;
        tick(8);
        n_cmp++; if (tx_log.size() !== e.size()) begin n_bad++; $display("FAIL stuff_len got=%0d exp=%0d", tx_log.size(), e.size()); end
        for (int i = 0; i < e.size(); i++) begin
            n_cmp++; if ((i < tx_log.size() ? tx_log[i] : 8'hxx) !== e[i]) begin n_bad++; $display("FAIL stuff_byte%0d got=%h exp=%h", i, (i < tx_log.size() ? tx_log[i] : 8'hxx), e[i]); end
        end
        n_cmp++; if (rd_pulses !== 2) begin n_bad++; $display("FAIL stuff_ready_pulses got=%0d exp=2", rd_pulses); end
    endtask
    task automatic test_backpressure();
        logic [7:0] e [$];
        e = '{8'hB1, 8'h3C, 8'h99};
        clear_pay(); push(2, 8'h99); req(2, 8'h3C, 4'd1);
        clear_logs();
        bus.REQ_VALID_I = 3'b100;
        tick();
        bus.REQ_VALID_I = 3'b000;
        tick();
        bus.TX_READY_I = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.TX_DATA_O !== 8'h3C || bus.TX_WRITE_O !== 1'b1) begin n_bad++; $display("FAIL bp_hold%0d got=%h/%b exp=3c/1", i, bus.TX_DATA_O, bus.TX_WRITE_O); end
            tick();
        end
        bus.TX_READY_I = 1'b1;
        tick(6);
        n_cmp++; if (tx_log.size() !== e.size()) begin n_bad++; $display("FAIL bp_len got=%0d exp=%0d", tx_log.size(), e.size()); end
        for (int i = 0; i < e.size(); i++) begin
            n_cmp++; if ((i < tx_log.size() ? tx_log[i] : 8'hxx) !== e[i]) begin n_bad++; $display("FAIL bp_byte%0d got=%h exp=%h", i, (i < tx_log.size() ? tx_log[i] : 8'hxx), e[i]); end
        end
    endtask
    task automatic test_round_robin();
        logic [7:0] e [$];
        int idx [$];
        logic [2:0] eg [$];
        e   = '{8'hB1, 8'h10, 8'hA0, 8'hB1, 8'h20, 8'hA1, 8'hB1, 8'h30, 8'hA2, 8'hB1, 8'h10, 8'hA3};
        idx = '{1, 3, 4, 5, 8, 9, 12, 13, 16, 17};
        eg  = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000, 3'b000};
        rst = 1'b1;
        clear_pay(); push(0, 8'hA0); push(0, 8'hA3); push(1, 8'hA1); push(2, 8'hA2);
        req(0, 8'h10, 4'd1); req(1, 8'h20, 4'd1); req(2, 8'h30, 4'd1);
        bus.REQ_VALID_I = 3'b111;
        tick();
        rst = 1'b0;
        clear_logs();
        tick(14);
        bus.REQ_VALID_I = 3'b000;
        tick(6);
        for (int i = 0; i < idx.size(); i++) begin
            n_cmp++; if (grant_log[idx[i]] !== eg[i]) begin n_bad++; $display("FAIL rr_grant_c%0d got=%b exp=%b", idx[i], grant_log[idx[i]], eg[i]); end
        end
        n_cmp++; if (tx_log.size() !== e.size()) begin n_bad++; $display("FAIL rr_len got=%0d exp=%0d", tx_log.size(), e.size()); end
        for (int i = 0; i < e.size(); i++) begin
            n_cmp++; if ((i < tx_log.size() ? tx_log[i] : 8'hxx) !== e[i]) begin n_bad++; $display("FAIL rr_byte%0d got=%h exp=%h", i, (i < tx_log.size() ? tx_log[i] : 8'hxx), e[i]); end
        end
    endtask
    task automatic test_len_bounds();
        logic [7:0] e [$];
        clear_pay(); req(0, 8'h55, 4'd0);
        clear_logs();
        bus.REQ_VALID_I = 3'b001;
        tick();
        bus.REQ_VALID_I = 3'b000;
        tick(4);
        n_cmp++; if (tx_log.size() !== 2) begin n_bad++; $display("FAIL len0_len got=%0d exp=2", tx_log.size()); end
        n_cmp++; if ((tx_log.size() > 1 ? tx_log[1] : 8'hxx) !== 8'h55) begin n_bad++; $display("FAIL len0_hdr got=%h exp=55", (tx_log.size() > 1 ? tx_log[1] : 8'hxx)); end
        n_cmp++; if (grant_log[3] !== 3'b000) begin n_bad++; $display("FAIL len0_end got=%b exp=000", grant_log[3]); end
        e = '{8'hB1, 8'h66, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        clear_pay();
        for (int i = 1; i <= 15; i++) push(1, 8'(i));
        req(1, 8'h66, 4'd15);
        clear_logs();
        bus.REQ_VALID_I = 3'b010;
        tick();
        bus.REQ_VALID_I = 3'b000;
        tick(14);
        n_cmp++; if (tx_log.size() !== e.size()) begin n_bad++; $display("FAIL len15_len got=%0d exp=%0d", tx_log.size(), e.size()); end
        for (int i = 0; i < e.size(); i++) begin
            n_cmp++; if ((i < tx_log.size() ? tx_log[i] : 8'hxx) !== e[i]) begin n_bad++; $display("FAIL len15_byte%0d got=%h exp=%h", i, (i < tx_log.size() ? tx_log[i] : 8'hxx), e[i]); end
        end
        n_cmp++; if (rd[1] !== 8) begin n_bad++; $display("FAIL len15_consumed got=%0d exp=8", rd[1]); end
    endtask
    task automatic test_stall();
        clear_pay(); req(0, 8'h77, 4'd1);
        clear_logs();
        bus.REQ_VALID_I = 3'b001;
        tick();
        bus.REQ_VALID_I = 3'b000;
        tick(6);
        n_cmp++; if (tx_log.size() !== 2) begin n_bad++; $display("FAIL stall_len got=%0d exp=2", tx_log.size()); end
        n_cmp++; if (bus.GRANT_O !== 3'b001 || bus.TX_WRITE_O !== 1'b0) begin n_bad++; $display("FAIL stall_state got=%b/%b exp=001/0", bus.GRANT_O, bus.TX_WRITE_O); end
        push(0, 8'h42);
        tick(4);
        n_cmp++; if (tx_log.size() !== 3 || (tx_log.size() > 2 ? tx_log[2] : 8'hxx) !== 8'h42) begin n_bad++; $display("FAIL stall_resume got=%0d/%h exp=3/42", tx_log.size(), (tx_log.size() > 2 ? tx_log[2] : 8'hxx)); end
        n_cmp++; if (bus.GRANT_O !== 3'b000) begin n_bad++; $display("FAIL stall_done got=%b exp=000", bus.GRANT_O); end
    endtask
    task automatic test_reset_mid();
        clear_pay();
        for (int i = 1; i <= 4; i++) push(2, 8'(i));
        req(2, 8'h88, 4'd4);
        bus.REQ_VALID_I = 3'b100;
        tick();
        bus.REQ_VALID_I = 3'b000;
        tick(3);
        n_cmp++; if (bus.TX_DATA_O !== 8'h02 || bus.TX_WRITE_O !== 1'b1) begin n_bad++; $display("FAIL mid_before got=%h/%b exp=02/1", bus.TX_DATA_O, bus.TX_WRITE_O); end
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.GRANT_O !== 3'b000) begin n_bad++; $display("FAIL mid_grant got=%b exp=000", bus.GRANT_O); end
        n_cmp++; if (bus.TX_WRITE_O !== 1'b0) begin n_bad++; $display("FAIL mid_txw got=%b exp=0", bus.TX_WRITE_O); end
        n_cmp++; if (bus.TX_DATA_O !== 8'h00) begin n_bad++; $display("FAIL mid_txd got=%h exp=00", bus.TX_DATA_O); end
        n_cmp++; if (bus.DATA_READY_O !== 3'b000) begin n_bad++; $display("FAIL mid_rdy got=%b exp=000", bus.DATA_READY_O); end
        clear_pay(); req(0, 8'hA5, 4'd0); req(1, 8'h5B, 4'd0);
        bus.REQ_VALID_I = 3'b011;
        tick();
        rst = 1'b0;
        clear_logs();
        tick();
        bus.REQ_VALID_I = 3'b000;
        tick(4);
        n_cmp++; if (grant_log[1] !== 3'b001) begin n_bad++; $display("FAIL mid_regrant got=%b exp=001", grant_log[1]); end
        n_cmp++; if (tx_log.size() !== 2 || tx_log[0] !== 8'hB1 || tx_log[1] !== 8'hA5) begin n_bad++; $display("FAIL mid_frame got=%0d bytes first=%h exp=2 bytes B1,A5", tx_log.size(), (tx_log.size() > 0 ? tx_log[0] : 8'hxx)); end
    endtask
    initial begin
        bus.REQ_VALID_I  = 3'b000;
        bus.REQ_HDR_I    = '0;
        bus.REQ_LEN_I    = '0;
        bus.DATA_I       = '0;
        bus.DATA_VALID_I = 3'b000;
        bus.TX_READY_I   = 1'b1;
        test_reset();
        test_single();
        test_stuff();
        test_backpressure();
        test_len_bounds();
        test_stall();
        test_reset_mid();
        test_round_robin();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
